// File: rtl/lcd_display_driver.sv
// HD44780-style LCD driver: power-up init, byte strobe timing, and signed
// 16-bit value to "sign + 5 digits" conversion written at line 1, column 0.
module lcd_display_driver #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int E_PULSE_CYCLES    = 12,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_clear,
    input  logic [15:0] req_value,
    output logic        init_done,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(POWERUP_CYCLES, CLEAR_WAIT_CYCLES),
                                    max_of(max_of(CMD_WAIT_CYCLES, E_PULSE_CYCLES), 16));
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_BYTE,
        IDLE,
        CONV,
        SEND_BYTE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    state_t         state;
    phase_t         phase;
    logic [CW-1:0]  cnt;
    logic [2:0]     byte_idx;
    logic           txn_clear;
    logic           neg;
    logic [15:0]    bin;
    logic [19:0]    bcd;

    logic [19:0]    bcd_adj;
    logic [19:0]    bcd_next;
    logic [15:0]    bin_next;
    logic [15:0]    magnitude;
    logic [3:0]     lead;
    logic [2:0]     nxt_idx;
    logic [7:0]     nxt_data;
    logic           nxt_rs;
    logic [3:0]     digit;
    logic           blank;
    logic [CW-1:0]  hold_last;
    logic           last_byte;

    assign lcd_rw = 1'b0;

    // Unsigned 16 bits is enough: negating -32768 gives 0x8000 = 32768.
    assign magnitude = req_value[15] ? (~req_value + 16'd1) : req_value;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 5; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[18:0], bin[15]};
        bin_next = {bin[14:0], 1'b0};
    end

    // lead[j]: digits 0..j (most significant first) are all zero.
    always_comb begin
        lead[0] = (bcd[19:16] == 4'd0);
        lead[1] = lead[0] && (bcd[15:12] == 4'd0);
        lead[2] = lead[1] && (bcd[11:8] == 4'd0);
        lead[3] = lead[2] && (bcd[7:4] == 4'd0);
    end

    always_comb begin
        nxt_idx  = byte_idx + 3'd1;
        nxt_data = 8'h00;
        nxt_rs   = 1'b0;
        digit    = 4'd0;
        blank    = 1'b0;
        case (nxt_idx)
            3'd2:    begin digit = bcd[19:16]; blank = lead[0]; end
            3'd3:    begin digit = bcd[15:12]; blank = lead[1]; end
            3'd4:    begin digit = bcd[11:8];  blank = lead[2]; end
            3'd5:    begin digit = bcd[7:4];   blank = lead[3]; end
            3'd6:    begin digit = bcd[3:0];   blank = 1'b0;    end
            default: begin digit = 4'd0;       blank = 1'b0;    end
        endcase
        if (state == INIT_BYTE) begin
            case (nxt_idx)
                3'd1:    nxt_data = 8'h0C;
                3'd2:    nxt_data = 8'h06;
                default: nxt_data = 8'h01;
            endcase
        end else begin
            nxt_rs = 1'b1;
            if (nxt_idx == 3'd1) begin
                nxt_data = neg ? 8'h2D : 8'h20;
            end else begin
                nxt_data = blank ? 8'h20 : {4'h3, digit};
            end
        end
    end

    assign hold_last = (lcd_data == 8'h01) ? CW'(CLEAR_WAIT_CYCLES - 1)
                                           : CW'(CMD_WAIT_CYCLES - 1);
    assign last_byte = (state == INIT_BYTE) ? (byte_idx == 3'd3)
                                            : (txn_clear || byte_idx == 3'd6);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PWR_WAIT;
            phase     <= PH_SETUP;
            cnt       <= '0;
            byte_idx  <= 3'd0;
            txn_clear <= 1'b0;
            neg       <= 1'b0;
            bin       <= 16'd0;
            bcd       <= 20'd0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            lcd_data  <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (cnt == CW'(POWERUP_CYCLES)) begin
                        state    <= INIT_BYTE;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                        byte_idx <= 3'd0;
                        lcd_data <= 8'h38;
                        lcd_rs   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        txn_clear <= req_clear;
                        cnt       <= '0;
                        byte_idx  <= 3'd0;
                        if (req_clear) begin
                            state    <= SEND_BYTE;
                            phase    <= PH_SETUP;
                            lcd_data <= 8'h01;
                            lcd_rs   <= 1'b0;
                        end else begin
                            state <= CONV;
                            neg   <= req_value[15];
                            bin   <= magnitude;
                            bcd   <= 20'd0;
                        end
                    end
                end

                CONV: begin
                    bcd <= bcd_next;
                    bin <= bin_next;
                    if (cnt == CW'(15)) begin
                        state    <= SEND_BYTE;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                        lcd_data <= 8'h80;
                        lcd_rs   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                INIT_BYTE, SEND_BYTE: begin
                    case (phase)
                        PH_SETUP: begin
                            phase <= PH_PULSE;
                            lcd_e <= 1'b1;
                            cnt   <= '0;
                        end
                        PH_PULSE: begin
                            if (cnt == CW'(E_PULSE_CYCLES - 1)) begin
                                phase <= PH_HOLD;
                                lcd_e <= 1'b0;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt == hold_last) begin
                                cnt <= '0;
                                if (last_byte) begin
                                    state     <= IDLE;
                                    req_ready <= 1'b1;
                                    if (state == INIT_BYTE) begin
                                        init_done <= 1'b1;
                                    end
                                end else begin
                                    phase    <= PH_SETUP;
                                    byte_idx <= nxt_idx;
                                    lcd_data <= nxt_data;
                                    lcd_rs   <= nxt_rs;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    endcase
                end

                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule
